frame_receiver69: RTL and testbench
===================================

// Module: frame_receiver69
// PURPOSE
//   Receive side of the 69-byte serial game frame: 0xFF start, D0..D2, 64 map bytes, 0xFE end.
//   Consumes one byte per strobe from the UART receiver.
//   Rebuilds D0..D2 and the 512-bit map (128 rows x 4 bits).
//   Publishes them atomically only when the end byte checks out.
//   Sits between the UART RX byte output and the game/display logic.
// PARAMETERS
//   START_BYTE      8'hFF    value that opens a frame
//   END_BYTE        8'hFE    value required at frame index 68
//   TIMEOUT_CYCLES  500000   inter-byte idle limit in clocks (used only with RX_TIMEOUT_EN)
// PORTS
//   clock        in   1    system clock; all logic on rising edge
//   reset        in   1    synchronous, active-high
//   byte_in      in   8    received byte, valid when byte_valid=1
//   byte_valid   in   1    each high cycle = exactly one byte
//   D0           out  8    data byte 0 of last good frame
//   D1           out  8    data byte 1 of last good frame
//   D2           out  8    data byte 2 of last good frame
//   map_data     out  512  map of last good frame
//   frame_valid  out  1    1-cycle pulse: outputs just updated
//   frame_error  out  1    1-cycle pulse: frame aborted
//   busy         out  1    1 while in a state other than IDLE
//   byte_count   out  7    index of next expected byte (0..68)
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; shadow registers 0.
//   Reset asserted mid-frame aborts the frame. No frame_error pulse is raised.
//   If reset and byte_valid occur together, reset wins.
//   FSM states and transitions (byte_count increments per accepted byte):
//     IDLE: byte_in==START_BYTE -> DATA, byte_count=1. Any other byte is ignored silently.
//     DATA: idx 1..3 -> shadow D0..D2. After idx 3 -> MAP.
//     MAP:  idx k=4..67 -> shadow_map[8*(k-4)+7 : 8*(k-4)]. After idx 67 -> END.
//     END:  if byte_in==END_BYTE: copy shadows to D0/D1/D2/map_data, pulse frame_valid, -> IDLE.
//           else: pulse frame_error, outputs unchanged, -> IDLE.
//   Payload is not escaped: 0xFF/0xFE inside DATA/MAP are stored as data. No in-frame resync.
//   Latency: outputs and frame_valid update on the edge that samples the end byte.
//     They are visible in the following cycle.
//   frame_valid and frame_error are never high together.
//   Outputs hold the previous good frame until the next good frame completes.
//   byte_count returns to 0 on entering IDLE.
//   busy = (state != IDLE).
// CONFIGURATION
//   RX_TIMEOUT_EN defined:
//     Idle counter clears on every byte_valid and while in IDLE.
//     If it reaches TIMEOUT_CYCLES while busy: pulse frame_error, go to IDLE.
//     Shadows are discarded and outputs are unchanged.
//     A byte_valid in the timeout cycle is ignored; it is not treated as a START.
//   RX_TIMEOUT_EN undefined: no counter exists; a stalled frame waits forever.
// STRUCTURE
//   Shared include frame_defs.vh holds:
//     FRAME_START=8'hFF, FRAME_END=8'hFE, FRAME_LEN=69, N_DATA=3, N_MAP_BYTES=64
//     State encodings IDLE/DATA/MAP/END (2 bits).
//   The transmit-side mux and its sequencer reuse these constants.
//   One sub-module: rx_timeout_timer (clear, enable, done).
//     Instantiated only under RX_TIMEOUT_EN.
// TESTING
//   1. Good frame FF,11,22,33, map bytes i=0..63 value i, FE:
//      D0=11, D1=22, D2=33; map_data[7:0]=00; map_data[511:504]=3F.
//      One frame_valid pulse; busy low afterwards.
//   2. Bad end: same frame with last byte 0x00.
//      One frame_error pulse; outputs keep the previous frame; byte_count=0.
//   3. Junk before start: 00,7E,FE, then a good frame.
//      Junk is ignored; busy stays 0 until FF; frame decodes correctly.
//   4. Payload contains FF and FE (D0=FF, map byte 0=FE):
//      Frame is accepted intact; no early restart.
//   5. Reset pulsed after byte 30:
//      All outputs 0, no pulses.
//      A following good frame decodes correctly.
//   6. RX_TIMEOUT_EN with TIMEOUT_CYCLES=100: stop after byte 10.
//      frame_error pulses at idle cycle 100; busy drops; a following frame works.

Source files
------------

// File: rtl/frame_receiver69_pkg.sv
// frame_receiver69_pkg: shared frame constants and receiver state encoding
package frame_receiver69_pkg;
  localparam logic [7:0] FRAME_START = 8'hFF;
  localparam logic [7:0] FRAME_END = 8'hFE;
  localparam int FRAME_LEN = 69;
  localparam int N_DATA = 3;
  localparam int N_MAP_BYTES = 64;
  localparam int MAP_W = 8 * N_MAP_BYTES;
  typedef enum logic [1:0] {IDLE, DATA, MAP, END} state_t;
endpackage

// File: rtl/frame_receiver69_timer.sv
// rx_timeout_timer: counts enabled cycles since the last clear and flags when LIMIT is reached
module rx_timeout_timer #(
  parameter int LIMIT = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    done = cnt_q == W'(LIMIT);
    cnt_d = clear ? '0 : (enable && !done) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/frame_receiver69.sv
// frame_receiver69: rebuilds a 69-byte game frame and publishes it atomically; RX_TIMEOUT_EN adds an inter-byte timeout
module frame_receiver69
  import frame_receiver69_pkg::*;
#(
  parameter logic [7:0] START_BYTE = FRAME_START,
  parameter logic [7:0] END_BYTE = FRAME_END,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic [7:0]       D0,
  output logic [7:0]       D1,
  output logic [7:0]       D2,
  output logic [MAP_W-1:0] map_data,
  output logic             frame_valid,
  output logic             frame_error,
  output logic             busy,
  output logic [6:0]       byte_count
);
  state_t state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [N_DATA-1:0][7:0] dsh_q, dsh_d, dout_q, dout_d;
  logic [MAP_W-1:0] msh_q, msh_d, map_q, map_d;
  logic fv_q, fv_d, fe_q, fe_d;
  logic [5:0] mi;
  logic timeout;
`ifdef RX_TIMEOUT_EN
  logic tmo_done;
  rx_timeout_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (byte_valid || state_q == IDLE),
    .enable (state_q != IDLE),
    .done   (tmo_done)
  );
  assign timeout = tmo_done && state_q != IDLE;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    dsh_d = dsh_q;
    msh_d = msh_q;
    dout_d = dout_q;
    map_d = map_q;
    fv_d = 1'b0;
    fe_d = 1'b0;
    mi = 6'(cnt_q - 7'd4);
    if (timeout) begin
      state_d = IDLE;
      cnt_d = '0;
      fe_d = 1'b1;
    end else if (byte_valid) begin
      case (state_q)
        IDLE: begin
          state_d = byte_in == START_BYTE ? DATA : IDLE;
          cnt_d = byte_in == START_BYTE ? 7'd1 : 7'd0;
        end
        DATA: begin
          dsh_d[2'(cnt_q - 7'd1)] = byte_in;
          cnt_d = cnt_q + 7'd1;
          state_d = cnt_q == 7'(N_DATA) ? MAP : DATA;
        end
        MAP: begin
          msh_d[{mi, 3'b000} +: 8] = byte_in;
          cnt_d = cnt_q + 7'd1;
          state_d = cnt_q == 7'(FRAME_LEN - 2) ? END : MAP;
        end
        default: begin
          state_d = IDLE;
          cnt_d = '0;
          fv_d = byte_in == END_BYTE;
          fe_d = byte_in != END_BYTE;
          dout_d = fv_d ? dsh_q : dout_q;
          map_d = fv_d ? msh_q : map_q;
        end
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dsh_q <= '0;
      msh_q <= '0;
      dout_q <= '0;
      map_q <= '0;
      fv_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dsh_q <= dsh_d;
      msh_q <= msh_d;
      dout_q <= dout_d;
      map_q <= map_d;
      fv_q <= fv_d;
      fe_q <= fe_d;
    end
  end
  assign D0 = dout_q[0];
  assign D1 = dout_q[1];
  assign D2 = dout_q[2];
  assign map_data = map_q;
  assign frame_valid = fv_q;
  assign frame_error = fe_q;
  assign busy = state_q != IDLE;
  assign byte_count = cnt_q;
endmodule

// File: tb/tb_frame_receiver69.sv
// tb_frame_receiver69: scoreboard bench for frame_receiver69 (timeout scenario enabled with RX_TIMEOUT_EN)
module tb_frame_receiver69;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [7:0] byte_in = '0;
  logic byte_valid = 1'b0;
  logic [7:0] D0, D1, D2;
  logic [511:0] map_data;
  logic frame_valid, frame_error, busy;
  logic [6:0] byte_count;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic ok;
    logic [7:0] d0, d1, d2;
    logic [511:0] map;
  } exp_t;
  exp_t sb[$];
  logic [7:0] g0 = '0, g1 = '0, g2 = '0;
  logic [511:0] gmap = '0;
  logic [511:0] m1, m3, m4;

  always #5 clock = ~clock;

  frame_receiver69 #(.TIMEOUT_CYCLES(100)) dut (
    .clock       (clock),
    .reset       (reset),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .D0          (D0),
    .D1          (D1),
    .D2          (D2),
    .map_data    (map_data),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .busy        (busy),
    .byte_count  (byte_count)
  );

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in = b;
    byte_valid = 1'b1;
    @(posedge clock);
    #1 byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic ok);
    exp_t x;
    x.ok = ok;
    x.d0 = g0;
    x.d1 = g1;
    x.d2 = g2;
    x.map = gmap;
    sb.push_back(x);
  endtask

  task automatic send_frame(input logic [7:0] a, b, c, input logic [511:0] m, input logic [7:0] e);
    if (e == 8'hFE) begin
      g0 = a;
      g1 = b;
      g2 = c;
      gmap = m;
    end
    push_exp(e == 8'hFE);
    send_byte(8'hFF);
    send_byte(a);
    send_byte(b);
    send_byte(c);
    for (int i = 0; i < 64; i++) send_byte(m[8*i +: 8]);
    send_byte(e);
    idle(2);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_d0"}, D0, 0);
    check_eq({tag, "_d1"}, D1, 0);
    check_eq({tag, "_d2"}, D2, 0);
    check_eq({tag, "_map"}, map_data, 0);
    check_eq({tag, "_fv"}, frame_valid, 0);
    check_eq({tag, "_fe"}, frame_error, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_cnt"}, byte_count, 0);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset && (frame_valid || frame_error)) begin
      check_eq("pulse_excl", frame_valid & frame_error, 0);
      check_eq("pulse_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("sb_valid", frame_valid, e.ok);
        check_eq("sb_error", frame_error, !e.ok);
        check_eq("sb_d0", D0, e.d0);
        check_eq("sb_d1", D1, e.d1);
        check_eq("sb_d2", D2, e.d2);
        check_eq("sb_map", map_data, e.map);
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) m1[8*i +: 8] = 8'(i);
    for (int i = 0; i < 16; i++) m3[32*i +: 32] = $urandom;
    m4 = m1;
    m4[7:0] = 8'hFE;
    m4[15:8] = 8'hFF;
    idle(3);
    check_zero("reset");
    reset = 1'b0;
    idle(1);
    send_frame(8'h11, 8'h22, 8'h33, m1, 8'hFE);
    check_eq("t1_d0", D0, 8'h11);
    check_eq("t1_d2", D2, 8'h33);
    check_eq("t1_map_lo", map_data[7:0], 8'h00);
    check_eq("t1_map_hi", map_data[511:504], 8'h3F);
    check_eq("t1_busy", busy, 0);
    send_frame(8'hAA, 8'hBB, 8'hCC, ~m1, 8'h00);
    check_eq("t2_d0", D0, 8'h11);
    check_eq("t2_map", map_data, m1);
    check_eq("t2_cnt", byte_count, 0);
    check_eq("t2_busy", busy, 0);
    send_byte(8'h00);
    check_eq("t3_busy0", busy, 0);
    send_byte(8'h7E);
    check_eq("t3_cnt", byte_count, 0);
    send_byte(8'hFE);
    check_eq("t3_busy2", busy, 0);
    send_frame(8'h01, 8'h02, 8'h03, m3, 8'hFE);
    check_eq("t3_map", map_data, m3);
    send_frame(8'hFF, 8'hFE, 8'hFF, m4, 8'hFE);
    check_eq("t4_d0", D0, 8'hFF);
    check_eq("t4_map", map_data[15:0], 16'hFFFE);
    send_byte(8'hFF);
    for (int i = 0; i < 29; i++) send_byte(8'(i + 8'h40));
    check_eq("t5_cnt", byte_count, 30);
    check_eq("t5_busy", busy, 1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    g0 = '0;
    g1 = '0;
    g2 = '0;
    gmap = '0;
    idle(2);
    check_zero("t5_after");
    send_frame(8'h5A, 8'hA5, 8'h3C, ~m3, 8'hFE);
    check_eq("t5_d1", D1, 8'hA5);
`ifdef RX_TIMEOUT_EN
    push_exp(1'b0);
    send_byte(8'hFF);
    for (int i = 0; i < 9; i++) send_byte(8'(i));
    check_eq("t6_busy_before", busy, 1);
    for (int i = 0; i < 300 && busy; i++) @(negedge clock);
    check_eq("t6_busy_dropped", busy, 0);
    idle(2);
    send_frame(8'h12, 8'h34, 8'h56, m1, 8'hFE);
    check_eq("t6_d0", D0, 8'h12);
`endif
    idle(2);
    check_eq("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
